imem_fetch: RTL and testbench
=============================

IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: instruction memory depth in 32-bit words; word index = pc[31:2].
REQ-002 Parameter WAIT_CYCLES, default 2: extra memory wait states per fetch, range 0..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-005 pc  input  32  fetch address from the fetch unit; held stable by the fetch unit while stall=1.
REQ-006 ld_we  input  1  memory load-port write strobe.
REQ-007 ld_addr  input  32  load-port byte address; word index = ld_addr[31:2].
REQ-008 ld_data  input  32  load-port write data.
REQ-009 instr  output  32  instruction for the current pc; meaningful only when instr_valid=1.
REQ-010 instr_valid  output  1  instr corresponds to the current pc.
REQ-011 stall  output  1  combinational; 1 = fetch unit holds pc this cycle; always equals !instr_valid.
REQ-012 addr_err  output  1  current instr was substituted because pc was misaligned or out of range.

Function
REQ-013 FSM states IDLE, FETCH, DONE; internal registers tag[31:0], cnt[3:0], instr, addr_err.
REQ-014 IDLE: instr_valid=0; next edge: tag<=pc, cnt<=WAIT_CYCLES, go to FETCH.
REQ-015 FETCH: instr_valid=0; if cnt!=0, decrement cnt; if cnt==0, load instr from mem[tag[31:2]] and go to DONE.
REQ-016 DONE with pc==tag: instr_valid=1, stall=0; the state is held.
REQ-017 DONE with pc!=tag: instr_valid=0, stall=1 in the same cycle; next edge: tag<=pc, cnt<=WAIT_CYCLES, go to FETCH.
REQ-018 Latency: a new pc first seen in a DONE cycle yields instr_valid=1 after 2+WAIT_CYCLES rising edges; stall is high for exactly 2+WAIT_CYCLES cycles.
REQ-019 Misaligned fetch (tag[1:0]!=0) or out of range (tag[31:2]>=DEPTH_WORDS) completes with the normal latency, instr=32'h00000013, addr_err=1.
REQ-020 addr_err is cleared whenever a new fetch is launched.
REQ-021 A load-port write is performed every edge with ld_we=1 and an in-range ld_addr; an out-of-range write is dropped silently.
REQ-022 A write whose word index equals tag[31:2] while in FETCH or DONE forces a transition to FETCH with cnt<=WAIT_CYCLES, so new data is returned.
REQ-023 When a write and a pc change coincide, the pc change takes precedence: tag<=pc and the fetch restarts.
REQ-024 The memory is not initialised by reset; contents persist across reset.

Reset
REQ-025 reset=0 at an edge: state<=IDLE, tag<=0, cnt<=0, instr<=0, addr_err<=0; outputs instr_valid=0, stall=1.
REQ-026 Reset during FETCH aborts the fetch with no instr update; an in-progress load-port write at the same edge is still performed.

Configuration
REQ-027 Macro IMEM_PREFETCH_EN: when defined, a one-entry next-line prefetch buffer (pf_tag, pf_instr, pf_valid, pf_cnt) is compiled in.
REQ-028 With IMEM_PREFETCH_EN, on entering DONE: pf_tag<=tag+4, pf_valid<=0, pf_cnt<=WAIT_CYCLES; while in DONE, pf_cnt counts down and then sets pf_valid with mem[pf_tag] (error substitution rules apply).
REQ-029 With IMEM_PREFETCH_EN, in DONE with pf_valid=1 and pc==pf_tag: instr_valid=1, stall=0, instr=pf_instr; next edge: tag<=pf_tag, instr<=pf_instr, and the prefetch restarts for pf_tag+4.
REQ-030 With IMEM_PREFETCH_EN, a pc mismatching both tag and a valid pf_tag, a write hitting pf_tag, or reset clears pf_valid.
REQ-031 Without IMEM_PREFETCH_EN, no prefetch logic exists; behaviour is exactly REQ-013..REQ-026.

Verification
REQ-032 Reset low 3 cycles, pc=0, mem[0]=32'h00500093, WAIT_CYCLES=2 -> stall=1 for 4 cycles after reset release, then instr=32'h00500093, instr_valid=1.
REQ-033 In DONE, pc steps 0->4 (mem[1]=32'h00100113) -> stall=1 for exactly 4 cycles, then instr=32'h00100113; with IMEM_PREFETCH_EN, once pf_valid=1 -> zero stall cycles.
REQ-034 pc=32'h00000006 -> after 4 cycles: instr=32'h00000013, addr_err=1; then pc=8 -> addr_err=0 once the new instr is valid.
REQ-035 pc=32'h00000400 with DEPTH_WORDS=256 -> instr=32'h00000013, addr_err=1.
REQ-036 In DONE at pc=8, ld_we=1, ld_addr=8, ld_data=32'hDEADBEEF -> stall returns to 1 next cycle, then instr=32'hDEADBEEF.
REQ-037 Reset asserted at the second FETCH cycle -> state IDLE, instr=0, stall=1; after release, a full fetch of the current pc completes with the normal latency.

Source files
------------

// File: rtl/imem_fetch.sv
// Instruction memory with a fixed-latency fetch FSM, a load port and error substitution.
// Define IMEM_PREFETCH_EN to compile in a one-entry next-line prefetch buffer.
module imem_fetch #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        stall,
    output logic        addr_err
);
    localparam int          AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT4 = 4'(WAIT_CYCLES);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_tag, w_tag_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic        r_addr_err, w_addr_err_nxt;
    logic        w_launch;
    logic        w_ld_ok;
    logic        w_wr_hit_tag;
    logic [32:0] w_rd_tag;
    logic        w_unused;

    logic [31:0] r_mem [DEPTH_WORDS];

    function automatic logic in_range(input logic [31:0] a);
        return {2'b00, a[31:2]} < 32'(DEPTH_WORDS);
    endfunction

    // Returns {err, data}; bad addresses yield a NOP with the error flag set.
    function automatic logic [32:0] lookup(input logic [31:0] a);
        if (a[1:0] != 2'b00 || !in_range(a))
            return {1'b1, NOP};
        return {1'b0, r_mem[a[AW+1:2]]};
    endfunction

    assign w_unused     = ^ld_addr[1:0];
    assign w_ld_ok      = ld_we && in_range(ld_addr);
    assign w_wr_hit_tag = w_ld_ok && (ld_addr[31:2] == r_tag[31:2]) && (r_state != IDLE);
    assign w_rd_tag     = lookup(r_tag);

    // Memory is never reset, so writes also land on reset edges.
    always_ff @(posedge clk) begin
        if (w_ld_ok)
            r_mem[ld_addr[AW+1:2]] <= ld_data;
    end

`ifdef IMEM_PREFETCH_EN
    logic [31:0] r_pf_tag;
    logic [31:0] r_pf_instr;
    logic        r_pf_err;
    logic        r_pf_valid;
    logic [3:0]  r_pf_cnt;
    logic        w_pf_hit;
    logic        w_wr_hit_pf;

    assign w_pf_hit    = (r_state == DONE) && r_pf_valid && (pc == r_pf_tag) && (pc != r_tag);
    assign w_wr_hit_pf = w_ld_ok && (ld_addr[31:2] == r_pf_tag[31:2]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pf_tag   <= 32'd0;
            r_pf_instr <= 32'd0;
            r_pf_err   <= 1'b0;
            r_pf_valid <= 1'b0;
            r_pf_cnt   <= 4'd0;
        end else if (r_state != DONE || w_state_nxt != DONE) begin
            r_pf_valid <= 1'b0;
            if (w_state_nxt == DONE) begin
                r_pf_tag <= w_tag_nxt + 32'd4;
                r_pf_cnt <= WAIT4;
            end
        end else if (w_pf_hit) begin
            r_pf_tag   <= r_pf_tag + 32'd4;
            r_pf_valid <= 1'b0;
            r_pf_cnt   <= WAIT4;
        end else if (w_wr_hit_pf) begin
            r_pf_valid <= 1'b0;
            r_pf_cnt   <= WAIT4;
        end else if (!r_pf_valid) begin
            if (r_pf_cnt != 4'd0)
                r_pf_cnt <= r_pf_cnt - 4'd1;
            else begin
                {r_pf_err, r_pf_instr} <= lookup(r_pf_tag);
                r_pf_valid             <= 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_tag_nxt      = r_tag;
        w_cnt_nxt      = r_cnt;
        w_instr_nxt    = r_instr;
        w_addr_err_nxt = r_addr_err;
        w_launch       = 1'b0;
        case (r_state)
            IDLE: begin
                w_tag_nxt = pc;
                w_launch  = 1'b1;
            end
            FETCH: begin
                if (w_wr_hit_tag)
                    w_launch = 1'b1;
                else if (r_cnt != 4'd0)
                    w_cnt_nxt = r_cnt - 4'd1;
                else begin
                    {w_addr_err_nxt, w_instr_nxt} = w_rd_tag;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // A pc change wins over a coincident write hit on the old tag.
                if (pc == r_tag) begin
                    if (w_wr_hit_tag)
                        w_launch = 1'b1;
                end
`ifdef IMEM_PREFETCH_EN
                else if (w_pf_hit) begin
                    w_tag_nxt = r_pf_tag;
                    if (w_wr_hit_pf)
                        w_launch = 1'b1;
                    else begin
                        w_instr_nxt    = r_pf_instr;
                        w_addr_err_nxt = r_pf_err;
                    end
                end
`endif
                else begin
                    w_tag_nxt = pc;
                    w_launch  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_launch) begin
            w_state_nxt    = FETCH;
            w_cnt_nxt      = WAIT4;
            w_addr_err_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_tag      <= 32'd0;
            r_cnt      <= 4'd0;
            r_instr    <= 32'd0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tag      <= w_tag_nxt;
            r_cnt      <= w_cnt_nxt;
            r_instr    <= w_instr_nxt;
            r_addr_err <= w_addr_err_nxt;
        end
    end

    always_comb begin
        instr_valid = (r_state == DONE) && (pc == r_tag);
        instr       = r_instr;
        addr_err    = r_addr_err;
`ifdef IMEM_PREFETCH_EN
        if (w_pf_hit) begin
            instr_valid = 1'b1;
            instr       = r_pf_instr;
            addr_err    = r_pf_err;
        end
`endif
    end

    assign stall = !instr_valid;

endmodule

// File: tb/tb_imem_fetch.sv
// Directed scoreboard bench for imem_fetch (default build, DEPTH_WORDS=256, WAIT_CYCLES=2).
module tb_imem_fetch;
    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic [31:0] pc      = 32'd0;
    logic        ld_we   = 1'b0;
    logic [31:0] ld_addr = 32'd0;
    logic [31:0] ld_data = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        addr_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] instr;
        logic        err;
        int          stalls;
    } exp_t;

    exp_t        sbQueue [$];
    logic [31:0] memModel [256];

    imem_fetch #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .instr      (instr),
        .instr_valid(instr_valid),
        .stall      (stall),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] modelFetch(input logic [31:0] a);
        if (a[1:0] != 2'b00 || a[31:2] >= 30'd256)
            return {1'b1, 32'h0000_0013};
        return {1'b0, memModel[a[9:2]]};
    endfunction

    task automatic pushExpected(input string tag, input logic [31:0] a, input int stalls);
        exp_t        e;
        logic [32:0] r;
        r        = modelFetch(a);
        e.tag    = tag;
        e.err    = r[32];
        e.instr  = r[31:0];
        e.stalls = stalls;
        sbQueue.push_back(e);
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] newPc, input int stalls);
        @(negedge clk);
        pc = newPc;
        pushExpected(tag, newPc, stalls);
    endtask

    task automatic loadWord(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        if (a[31:2] < 30'd256)
            memModel[a[9:2]] = d;
    endtask

    // Counts stall cycles until instr_valid, then pops and compares the scoreboard entry.
    task automatic checkOutput();
        exp_t e;
        int   n   = 0;
        logic got = 1'b0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            n++;
            @(negedge clk);
            #1;
        end
        checkEq("valid_within_budget", 32'(got), 32'd1);
        checkEq("sb_nonempty", 32'(sbQueue.size() != 0), 32'd1);
        if (sbQueue.size() != 0) begin
            e = sbQueue.pop_front();
            checkEq({e.tag, "_stalls"}, n, e.stalls);
            checkEq({e.tag, "_instr"}, instr, e.instr);
            checkEq({e.tag, "_err"}, 32'(addr_err), 32'(e.err));
            checkEq({e.tag, "_stall_low"}, 32'(stall), 32'd0);
        end
    endtask

    initial begin
        // Preload memory through the load port while reset is held.
        loadWord(32'h0000_0000, 32'h0050_0093);
        loadWord(32'h0000_0004, 32'h0010_0113);
        loadWord(32'h0000_0008, 32'h00A0_0193);
        loadWord(32'h0000_03FC, 32'hCAFE_F00D);
        @(negedge clk);
        ld_we = 1'b0;
        #1;
        checkEq("rst_valid", 32'(instr_valid), 32'd0);
        checkEq("rst_stall", 32'(stall), 32'd1);
        checkEq("rst_instr", instr, 32'd0);
        checkEq("rst_err", 32'(addr_err), 32'd0);

        @(negedge clk);
        reset = 1'b1;
        pushExpected("boot_pc0", 32'h0, 4);
        checkOutput();

        applyStimulus("pc4", 32'h4, 4);
        checkOutput();
        applyStimulus("misaligned6", 32'h6, 4);
        checkOutput();
        applyStimulus("pc8", 32'h8, 4);
        checkOutput();

        // Write hitting the current tag restarts the fetch with fresh data.
        loadWord(32'h0000_0008, 32'hDEAD_BEEF);
        #1;
        checkEq("wrhit_pre_stall", 32'(stall), 32'd0);
        pushExpected("wrhit", 32'h8, 3);
        @(negedge clk);
        ld_we = 1'b0;
        #1;
        checkEq("wrhit_stall_next", 32'(stall), 32'd1);
        checkOutput();

        // Writes elsewhere, including a dropped out-of-range one, leave the fetch alone.
        loadWord(32'h0000_000C, 32'h00C0_0213);
        loadWord(32'h0000_0800, 32'h1234_5678);
        @(negedge clk);
        ld_we = 1'b0;
        #1;
        checkEq("wrmiss_stall", 32'(stall), 32'd0);
        checkEq("wrmiss_instr", instr, 32'hDEAD_BEEF);

        applyStimulus("oor400", 32'h400, 4);
        checkOutput();
        applyStimulus("lastword", 32'h3FC, 4);
        checkOutput();
        applyStimulus("pcC", 32'hC, 4);
        checkOutput();

        // pc change and write hit on the old tag in the same cycle.
        @(negedge clk);
        pc      = 32'h0;
        ld_we   = 1'b1;
        ld_addr = 32'hC;
        ld_data = 32'hABCD_EF01;
        memModel[3] = 32'hABCD_EF01;
        pushExpected("coincide_pc0", 32'h0, 4);
        checkOutput();
        ld_we = 1'b0;
        applyStimulus("pcC_new", 32'hC, 4);
        checkOutput();

        // Reset lands on the second FETCH cycle of a fetch for pc 4.
        @(negedge clk);
        pc = 32'h4;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        checkEq("midrst_valid", 32'(instr_valid), 32'd0);
        checkEq("midrst_stall", 32'(stall), 32'd1);
        checkEq("midrst_instr", instr, 32'd0);
        checkEq("midrst_err", 32'(addr_err), 32'd0);
        reset = 1'b1;
        pushExpected("after_midrst", 32'h4, 4);
        checkOutput();

        checkEq("sb_drained", 32'(sbQueue.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
